// File: rtl/ram_pkg.sv
// Shared helpers for the dual-port RAM: address split widths, parity width
// and the collision-resolution mode.
package ram_pkg;

  typedef enum logic [0:0] {
    A_WINS = 1'b0
  } coll_mode_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned par_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_2p_rd_pipe.sv
// Per-port response pipeline: holds rvalid/rdata/coll/rerr, with an optional
// second register stage when OutReg is set.
module ram_2p_rd_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned OutReg    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req,
  input  logic [DataWidth-1:0] word,
  input  logic                 coll_det,
  input  logic                 perr,
  output logic                 rvalid,
  output logic [DataWidth-1:0] rdata,
  output logic                 coll,
  output logic                 rerr
);

  logic                 s1_valid;
  logic [DataWidth-1:0] s1_data;
  logic                 s1_coll;
  logic                 s1_err;

  // rdata only moves on a request; flags are qualified so they never outlive rvalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_coll  <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= req;
      s1_coll  <= req & coll_det;
      s1_err   <= req & perr;
      if (req) begin
        s1_data <= word;
      end
    end
  end

  if (OutReg != 0) begin : g_outreg
    logic                 s2_valid;
    logic [DataWidth-1:0] s2_data;
    logic                 s2_coll;
    logic                 s2_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
        s2_coll  <= 1'b0;
        s2_err   <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        s2_coll  <= s1_coll;
        s2_err   <= s1_err;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rvalid = s2_valid;
    assign rdata  = s2_data;
    assign coll   = s2_coll;
    assign rerr   = s2_err;
  end else begin : g_direct
    assign rvalid = s1_valid;
    assign rdata  = s1_data;
    assign coll   = s1_coll;
    assign rerr   = s1_err;
  end

endmodule

// File: rtl/ram_2p.sv
// True dual-port RAM, read-first, port A wins shared lanes on a write collision.
// RAM_PARITY_EN adds per-byte even parity; load_word gives a backdoor write path.
module ram_2p
  import ram_pkg::*;
#(
  parameter int unsigned Depth     = 16384,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned OutReg    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   a_req_i,
  input  logic                   a_we_i,
  input  logic [DataWidth/8-1:0] a_be_i,
  input  logic [31:0]            a_addr_i,
  input  logic [DataWidth-1:0]   a_wdata_i,
  output logic                   a_rvalid_o,
  output logic [DataWidth-1:0]   a_rdata_o,
  output logic                   a_coll_o,
  input  logic                   b_req_i,
  input  logic                   b_we_i,
  input  logic [DataWidth/8-1:0] b_be_i,
  input  logic [31:0]            b_addr_i,
  input  logic [DataWidth-1:0]   b_wdata_i,
  output logic                   b_rvalid_o,
  output logic [DataWidth-1:0]   b_rdata_o,
  output logic                   b_coll_o
`ifdef RAM_PARITY_EN
  ,
  output logic                   a_rerr_o,
  output logic                   b_rerr_o
`endif
);

  localparam int unsigned Aw       = idx_width(Depth);
  localparam int unsigned Ob       = off_width(DataWidth);
  localparam int unsigned NumBytes = par_width(DataWidth);
  localparam coll_mode_e  CollMode = A_WINS;

  logic [DataWidth-1:0] mem [Depth];
  logic [Aw-1:0]        a_idx, b_idx;
  logic [NumBytes-1:0]  a_lane_we, b_lane_we, b_lane_keep;
  logic                 same_idx, coll_det;
  logic [DataWidth-1:0] a_word, b_word;
  logic                 a_perr, b_perr;
  logic                 a_rerr_q, b_rerr_q;
  logic                 unused_addr;

  assign a_idx       = a_addr_i[Aw+Ob-1:Ob];
  assign b_idx       = b_addr_i[Aw+Ob-1:Ob];
  assign unused_addr = ^{a_addr_i, b_addr_i};
  assign same_idx    = (a_idx == b_idx);
  assign coll_det    = a_req_i & b_req_i & same_idx & (a_we_i | b_we_i);
  assign a_lane_we   = {NumBytes{a_req_i & a_we_i}} & a_be_i;
  assign b_lane_we   = {NumBytes{b_req_i & b_we_i}} & b_be_i;

  always_comb begin
    b_lane_keep = b_lane_we;
    if (same_idx && CollMode == A_WINS) begin
      b_lane_keep = b_lane_we & ~a_lane_we;
    end
  end

  // Array read is combinational here; the response pipe registers it, so reads
  // see the word as it was before this cycle's writes land.
  assign a_word = mem[a_idx];
  assign b_word = mem[b_idx];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (b_lane_keep[i]) mem[b_idx][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      if (a_lane_we[i])   mem[a_idx][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
    end
  end

`ifdef RAM_PARITY_EN
  logic [NumBytes-1:0] par_mem [Depth];

  function automatic logic [NumBytes-1:0] lane_par(input logic [DataWidth-1:0] w);
    logic [NumBytes-1:0] p;
    p = '0;
    for (int i = 0; i < NumBytes; i++) p[i] = ^w[i*8 +: 8];
    return p;
  endfunction

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (b_lane_keep[i]) par_mem[b_idx][i] <= ^b_wdata_i[i*8 +: 8];
      if (a_lane_we[i])   par_mem[a_idx][i] <= ^a_wdata_i[i*8 +: 8];
    end
  end

  assign a_perr = |(lane_par(a_word) ^ par_mem[a_idx]);
  assign b_perr = |(lane_par(b_word) ^ par_mem[b_idx]);

  task automatic inject_parity_flip(input logic [Aw-1:0] index, input int unsigned lane);
    logic [NumBytes-1:0] mask;
    mask = NumBytes'(1) << lane;
    par_mem[index] <= par_mem[index] ^ mask;
  endtask
`else
  assign a_perr = 1'b0;
  assign b_perr = 1'b0;
`endif

  task automatic load_word(input logic [Aw-1:0] index, input logic [DataWidth-1:0] data);
    mem[index] <= data;
`ifdef RAM_PARITY_EN
    par_mem[index] <= lane_par(data);
`endif
  endtask

  ram_2p_rd_pipe #(.DataWidth(DataWidth), .OutReg(OutReg)) u_pipe_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req      (a_req_i),
    .word     (a_word),
    .coll_det (coll_det),
    .perr     (a_perr),
    .rvalid   (a_rvalid_o),
    .rdata    (a_rdata_o),
    .coll     (a_coll_o),
    .rerr     (a_rerr_q)
  );

  ram_2p_rd_pipe #(.DataWidth(DataWidth), .OutReg(OutReg)) u_pipe_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req      (b_req_i),
    .word     (b_word),
    .coll_det (coll_det),
    .perr     (b_perr),
    .rvalid   (b_rvalid_o),
    .rdata    (b_rdata_o),
    .coll     (b_coll_o),
    .rerr     (b_rerr_q)
  );

`ifdef RAM_PARITY_EN
  assign a_rerr_o = a_rerr_q;
  assign b_rerr_o = b_rerr_q;
`else
  logic unused_rerr;
  assign unused_rerr = a_rerr_q ^ b_rerr_q;
`endif

endmodule

// File: tb/tb_ram_2p.sv
// Bench for ram_2p: two instances (OutReg 0 and 1) share stimulus and are checked
// against a word-array reference model with read-first and A-wins rules.
module tb_ram_2p;

  localparam int unsigned Depth = 64;
  localparam int unsigned DataWidth = 32;

  typedef struct packed {
    logic        valid;
    logic        known;
    logic [31:0] data;
    logic        coll;
    logic        err;
  } resp_t;

  logic clk_i = 1'b0;
  logic rst_ni;

  logic        req   [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic        rvalid [2][2];
  logic [31:0] rdata  [2][2];
  logic        coll   [2][2];
`ifdef RAM_PARITY_EN
  logic        rerr   [2][2];
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [Depth];
  bit          written   [Depth];
  logic [3:0]  flipped   [Depth];
  resp_t       prev_resp [2];
  resp_t       exp_resp  [2][2];
  logic [31:0] last_data [2][2];
  bit          last_known [2][2];

  always #5 clk_i = ~clk_i;

  ram_2p #(.Depth(Depth), .DataWidth(DataWidth), .OutReg(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(req[0]), .a_we_i(we[0]), .a_be_i(be[0]), .a_addr_i(addr[0]), .a_wdata_i(wdata[0]),
    .a_rvalid_o(rvalid[0][0]), .a_rdata_o(rdata[0][0]), .a_coll_o(coll[0][0]),
    .b_req_i(req[1]), .b_we_i(we[1]), .b_be_i(be[1]), .b_addr_i(addr[1]), .b_wdata_i(wdata[1]),
    .b_rvalid_o(rvalid[0][1]), .b_rdata_o(rdata[0][1]), .b_coll_o(coll[0][1])
`ifdef RAM_PARITY_EN
    , .a_rerr_o(rerr[0][0]), .b_rerr_o(rerr[0][1])
`endif
  );

  ram_2p #(.Depth(Depth), .DataWidth(DataWidth), .OutReg(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(req[0]), .a_we_i(we[0]), .a_be_i(be[0]), .a_addr_i(addr[0]), .a_wdata_i(wdata[0]),
    .a_rvalid_o(rvalid[1][0]), .a_rdata_o(rdata[1][0]), .a_coll_o(coll[1][0]),
    .b_req_i(req[1]), .b_we_i(we[1]), .b_be_i(be[1]), .b_addr_i(addr[1]), .b_wdata_i(wdata[1]),
    .b_rvalid_o(rvalid[1][1]), .b_rdata_o(rdata[1][1]), .b_coll_o(coll[1][1])
`ifdef RAM_PARITY_EN
    , .a_rerr_o(rerr[1][0]), .b_rerr_o(rerr[1][1])
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setPort(input int p, input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
    req[p] = r; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
  endtask

  task automatic idlePorts();
    setPort(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    setPort(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Compare every output of both instances against the model's expectation
  task automatic checkAll();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        resp_t e;
        e = exp_resp[d][p];
        if (e.valid) begin
          last_data[d][p]  = e.data;
          last_known[d][p] = e.known;
        end
        checkOutput($sformatf("rvalid d%0d p%0d", d, p), 32'(rvalid[d][p]), 32'(e.valid));
        if (last_known[d][p])
          checkOutput($sformatf("rdata d%0d p%0d", d, p), rdata[d][p], last_data[d][p]);
        checkOutput($sformatf("coll d%0d p%0d", d, p), 32'(coll[d][p]), 32'(e.valid & e.coll));
`ifdef RAM_PARITY_EN
        checkOutput($sformatf("rerr d%0d p%0d", d, p), 32'(rerr[d][p]), 32'(e.valid & e.err));
`endif
      end
    end
  endtask

  task automatic clearModelPipe();
    prev_resp = '{default: '0};
    exp_resp  = '{default: '0};
    last_data = '{default: '0};
    last_known = '{default: 1'b1};
  endtask

  // One clock of traffic: model reads first, then applies writes (B then A so A wins shared lanes)
  task automatic applyStimulus();
    resp_t now [2];
    int unsigned ix [2];
    bit hit;
    for (int p = 0; p < 2; p++) ix[p] = (addr[p] / 4) % Depth;
    hit = req[0] && req[1] && ix[0] == ix[1] && (we[0] || we[1]);
    for (int p = 0; p < 2; p++) begin
      now[p] = '0;
      now[p].valid = req[p];
      if (req[p]) begin
        now[p].known = written[ix[p]];
        now[p].data  = model_mem[ix[p]];
        now[p].coll  = hit;
        now[p].err   = |flipped[ix[p]];
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (req[p] && we[p]) begin
        for (int l = 0; l < 4; l++) begin
          if (be[p][l]) begin
            model_mem[ix[p]][8*l +: 8] = wdata[p][8*l +: 8];
            flipped[ix[p]][l] = 1'b0;
          end
        end
        if (be[p] == 4'hF) written[ix[p]] = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    exp_resp[0] = now;
    exp_resp[1] = prev_resp;
    prev_resp = now;
    checkAll();
  endtask

  task automatic pulseReset();
    rst_ni = 1'b0;
    #1;
    clearModelPipe();
    checkAll();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int seen;
    idlePorts();
    for (int i = 0; i < Depth; i++) begin
      written[i] = 1'b0;
      flipped[i] = 4'h0;
      model_mem[i] = '0;
    end
    rst_ni = 1'b0;
    clearModelPipe();
    repeat (2) @(posedge clk_i);
    #1;
    checkAll();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic write then read
    setPort(0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF); applyStimulus();
    setPort(0, 1, 0, 4'h0, 32'h10, 32'h0);        applyStimulus();
    checkOutput("deadbeef read", rdata[0][0], 32'hDEADBEEF);
    idlePorts(); applyStimulus();
    checkOutput("deadbeef outreg", rdata[1][0], 32'hDEADBEEF);

    // Byte enables
    setPort(0, 1, 1, 4'hF, 32'h20, 32'h11223344); applyStimulus();
    setPort(0, 1, 1, 4'h5, 32'h20, 32'hAABBCCDD); applyStimulus();
    setPort(0, 1, 0, 4'h0, 32'h20, 32'h0);        applyStimulus();
    checkOutput("byte enable merge", rdata[0][0], 32'h11BB33DD);

    // Write/write collision on one word
    setPort(0, 1, 1, 4'hF, 32'h40, 32'h0); idlePorts(); setPort(0, 1, 1, 4'hF, 32'h40, 32'h0);
    applyStimulus();
    setPort(0, 1, 1, 4'h3, 32'h40, 32'h000000FF);
    setPort(1, 1, 1, 4'h6, 32'h40, 32'hFFFF0000);
    applyStimulus();
    checkOutput("ww coll a", 32'(coll[0][0]), 32'd1);
    checkOutput("ww coll b", 32'(coll[0][1]), 32'd1);
    idlePorts(); setPort(0, 1, 0, 4'h0, 32'h40, 32'h0); applyStimulus();
    checkOutput("ww merged word", rdata[0][0], 32'h00FF00FF);

    // Read-first across ports
    setPort(0, 1, 1, 4'hF, 32'h40, 32'h12345678); applyStimulus();
    setPort(0, 1, 0, 4'h0, 32'h40, 32'h0);
    setPort(1, 1, 1, 4'hF, 32'h40, 32'h0);
    applyStimulus();
    checkOutput("read-first data", rdata[0][0], 32'h12345678);
    checkOutput("rw coll a", 32'(coll[0][0]), 32'd1);
    checkOutput("rw coll b", 32'(coll[0][1]), 32'd1);
    idlePorts(); setPort(0, 1, 0, 4'h0, 32'h40, 32'h0); applyStimulus();
    checkOutput("read after rw", rdata[0][0], 32'h0);
    idlePorts(); applyStimulus();

    // Fill every word so random reads have known contents
    for (int i = 0; i < Depth / 2; i++) begin
      setPort(0, 1, 1, 4'hF, 32'(2 * i * 4), $urandom());
      setPort(1, 1, 1, 4'hF, 32'(((2 * i) + 1) * 4), $urandom());
      applyStimulus();
    end

    // Random traffic biased onto a few words to provoke collisions
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        int unsigned ix;
        ix = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, Depth - 1);
        a = ($urandom() & 32'hFFFF_FF00) | 32'(ix * 4) | 32'($urandom_range(0, 3));
        setPort(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)), a, $urandom());
      end
      applyStimulus();
    end

    // Back-to-back reads through the two-stage pipe
    idlePorts(); applyStimulus(); applyStimulus();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      idlePorts();
      if (i < 4) setPort(0, 1, 0, 4'h0, 32'(i * 4), 32'h0);
      applyStimulus();
      if (rvalid[1][0]) seen++;
    end
    checkOutput("outreg response count", 32'(seen), 32'd4);

    // Reset lands while responses are in flight
    setPort(0, 1, 0, 4'h0, 32'h4, 32'h0); applyStimulus();
    setPort(0, 1, 0, 4'h0, 32'h8, 32'h0); applyStimulus();
    pulseReset();
    checkOutput("reset drops rvalid", 32'(rvalid[1][0]), 32'd0);
    idlePorts(); setPort(0, 1, 0, 4'h0, 32'h10, 32'h0); applyStimulus();
    idlePorts(); applyStimulus();

`ifdef RAM_PARITY_EN
    setPort(0, 1, 1, 4'hF, 32'h50, 32'hCAFEF00D); applyStimulus();
    idlePorts(); applyStimulus();
    dut0.inject_parity_flip(6'd20, 2);
    dut1.inject_parity_flip(6'd20, 2);
    flipped[20][2] = 1'b1;
    setPort(0, 1, 0, 4'h0, 32'h50, 32'h0); applyStimulus();
    checkOutput("parity data", rdata[0][0], 32'hCAFEF00D);
    checkOutput("parity rerr", 32'(rerr[0][0]), 32'd1);
    setPort(0, 1, 0, 4'h0, 32'h10, 32'h0); applyStimulus();
    checkOutput("parity clean", 32'(rerr[0][0]), 32'd0);
    idlePorts(); applyStimulus();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
